trig_pulse_gen: RTL and testbench

//  Output-side counterpart of the switch debouncer. It drives a clean, timed

---
 rtl/trig_pulse_gen_if.sv | 24 ++
 rtl/trig_pulse_gen.sv | 112 +++++++++++
 tb/tb_trig_pulse_gen.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/trig_pulse_gen_if.sv
// Handshake bundle between scan control logic and the trigger pulse generator.
// The slave modport is the generator side; the master modport is the requester side.
interface trig_pulse_gen_if #(
  parameter int PEND_W = 4
);
  logic              enable;
  logic              trig_req;
  logic              clr_ovf;
  logic              line_out;
  logic              busy;
  logic [PEND_W-1:0] pend_cnt;
  logic              pulse_done;
  logic              overflow;

  modport master (
    output enable, trig_req, clr_ovf,
    input  line_out, busy, pend_cnt, pulse_done, overflow
  );

  modport slave (
    input  enable, trig_req, clr_ovf,
    output line_out, busy, pend_cnt, pulse_done, overflow
  );
endinterface

// File: rtl/trig_pulse_gen.sv
// Timed trigger strobe generator: each queued request becomes one fixed-width
// pulse on line_out followed by a mandatory idle hold-off gap.
module trig_pulse_gen #(
  parameter int   PULSE_CYC = 40,
  parameter int   GAP_CYC   = 200000,
  parameter int   PEND_W    = 4,
  parameter logic IDLE_LVL  = 1'b0
) (
  input  logic                  clk_cis,
  input  logic                  rst_n,
  trig_pulse_gen_if.slave       bus
);

  localparam logic [31:0]       P_LAST   = 32'(PULSE_CYC - 1);
  localparam logic [31:0]       G_LAST   = 32'(GAP_CYC - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_GAP} state_t;

  state_t            state_q, state_d;
  logic [31:0]       timer_q, timer_d;
  logic [PEND_W-1:0] pend_cnt_q, pend_cnt_d;
  logic              line_out_q, line_out_d;
  logic              pulse_done_q, pulse_done_d;
  logic              overflow_q, overflow_d;
  logic              can_start, start, enq, ovf_set;

  // Queued requests are flushed rather than started once enable drops.
  assign can_start = bus.enable && (pend_cnt_q != '0);
  assign enq       = bus.enable && bus.trig_req;

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    start        = 1'b0;
    pulse_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (can_start) begin
          state_d = S_ASSERT;
          timer_d = '0;
          start   = 1'b1;
        end
      end
      S_ASSERT: begin
        if (timer_q == P_LAST) begin
          state_d      = S_GAP;
          timer_d      = '0;
          pulse_done_d = 1'b1;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      S_GAP: begin
        if (timer_q == G_LAST) begin
          timer_d = '0;
          if (can_start) begin
            state_d = S_ASSERT;
            start   = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Registered line level follows the state being entered, so edges align with transitions.
    line_out_d = (state_d == S_ASSERT) ? ~IDLE_LVL : IDLE_LVL;
  end

  always_comb begin
    pend_cnt_d = pend_cnt_q;
    ovf_set    = 1'b0;
    if (!bus.enable) begin
      pend_cnt_d = '0;
    end else if (enq && !start) begin
      if (pend_cnt_q == PEND_MAX) ovf_set = 1'b1;
      else                        pend_cnt_d = pend_cnt_q + PEND_ONE;
    end else if (start && !enq) begin
      pend_cnt_d = pend_cnt_q - PEND_ONE;
    end
    overflow_d = ovf_set ? 1'b1 : (bus.clr_ovf ? 1'b0 : overflow_q);
  end

  always_ff @(posedge clk_cis or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      pend_cnt_q   <= '0;
      line_out_q   <= IDLE_LVL;
      pulse_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      pend_cnt_q   <= pend_cnt_d;
      line_out_q   <= line_out_d;
      pulse_done_q <= pulse_done_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.line_out   = line_out_q;
  assign bus.pulse_done = pulse_done_q;
  assign bus.overflow   = overflow_q;
  assign bus.pend_cnt   = pend_cnt_q;
  assign bus.busy       = (state_q != S_IDLE) || (pend_cnt_q != '0);

endmodule

// File: tb/tb_trig_pulse_gen.sv
// Bench for trig_pulse_gen: table vectors, hand-written corner sequences and a
// randomized run, all compared against a timeline-based reference model.
module tb_trig_pulse_gen;
  localparam int P    = 4;
  localparam int G    = 10;
  localparam int PW   = 2;
  localparam int MAXP = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  trig_pulse_gen_if #(.PEND_W(PW)) tpg_if();

  trig_pulse_gen #(.PULSE_CYC(P), .GAP_CYC(G), .PEND_W(PW), .IDLE_LVL(1'b0)) dut (
    .clk_cis (clk),
    .rst_n   (rst_n),
    .bus     (tpg_if)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: remembers the edge the last pulse started on and derives
  // line/done/busy from elapsed time; the queue is a plain integer count.
  int m_t, m_s, m_pend;
  bit m_has, m_ovf;

  typedef struct {
    bit en, req, clr;
    bit line, done, busy, ovf;
    int pend;
  } vec_t;
  vec_t tv[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_s = 0; m_has = 0; m_pend = 0; m_ovf = 0;
  endtask

  task automatic model_edge(input bit en, input bit req, input bit clr);
    bit free, start, enq, set;
    m_t++;
    free  = !m_has || (m_t - m_s >= P + G);
    start = free && (m_pend > 0) && en;
    if (start) begin m_s = m_t; m_has = 1; end
    enq = en && req;
    set = enq && (m_pend == MAXP) && !start;
    if (!en) m_pend = 0;
    else if (enq && !start && m_pend < MAXP) m_pend++;
    else if (start && !enq) m_pend--;
    if (set) m_ovf = 1;
    else if (clr) m_ovf = 0;
  endtask

  function automatic logic [5:0] model_out();
    bit line, done, busy;
    line = m_has && (m_t - m_s < P);
    done = m_has && (m_t - m_s == P);
    busy = (m_has && (m_t - m_s < P + G)) || (m_pend != 0);
    return {line, done, busy, m_ovf, m_pend[1:0]};
  endfunction

  function automatic logic [5:0] dut_out();
    return {tpg_if.line_out, tpg_if.pulse_done, tpg_if.busy, tpg_if.overflow, tpg_if.pend_cnt};
  endfunction

  task automatic step(input bit en, input bit req, input bit clr);
    @(negedge clk);
    tpg_if.enable = en; tpg_if.trig_req = req; tpg_if.clr_ovf = clr;
    @(posedge clk);
    model_edge(en, req, clr);
    #1;
    chk("model", 32'(dut_out()), 32'(model_out()));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    tpg_if.enable = 1'b1; tpg_if.trig_req = 1'b0; tpg_if.clr_ovf = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  int rises[$];
  int cnt;
  logic prev_line;
  logic [PW-1:0] pend_seq [3];

  initial begin
    tpg_if.enable = 1'b1; tpg_if.trig_req = 1'b0; tpg_if.clr_ovf = 1'b0;
    model_reset();
    for (int i = 0; i < 16; i++)
      tv[i] = '{1'b1, (i == 0), 1'b0, (i >= 1 && i <= 4), (i == 5), (i < 15), 1'b0, (i == 0) ? 1 : 0};

    #1;
    chk("reset_state", 32'(dut_out()), 32'(6'b000000));
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Single request at edge 5: four-cycle pulse, one done strobe, idle by edge 20.
    repeat (4) step(1, 0, 0);
    for (int i = 0; i < 16; i++) begin
      step(tv[i].en, tv[i].req, tv[i].clr);
      chk($sformatf("tv_row%0d", i), 32'(dut_out()),
          32'({tv[i].line, tv[i].done, tv[i].busy, tv[i].ovf, 2'(tv[i].pend)}));
    end

    // Three requests: pulses start 14 cycles apart, queue drains 1 then 0.
    do_reset();
    rises.delete();
    prev_line = 1'b0; cnt = 0;
    for (int i = 0; i < 48; i++) begin
      step(1, (i < 3), 0);
      if (i < 3) pend_seq[i] = tpg_if.pend_cnt;
      if (tpg_if.line_out && !prev_line) begin
        rises.push_back(i);
        if (cnt == 1) chk("t2_pend_at_rise2", 32'(tpg_if.pend_cnt), 32'd1);
        if (cnt == 2) chk("t2_pend_at_rise3", 32'(tpg_if.pend_cnt), 32'd0);
        cnt++;
      end
      prev_line = tpg_if.line_out;
    end
    chk("t2_pend_seq", 32'({pend_seq[0], pend_seq[1], pend_seq[2]}), 32'(6'b01_01_10));
    chk("t2_num_pulses", 32'(rises.size()), 32'd3);
    if (rises.size() == 3) begin
      chk("t2_period_a", 32'(rises[1] - rises[0]), 32'(P + G));
      chk("t2_period_b", 32'(rises[2] - rises[1]), 32'(P + G));
    end

    // Five back-to-back requests saturate the queue; drop beats clr_ovf.
    do_reset();
    repeat (5) step(1, 1, 0);
    chk("t3_pend_sat", 32'(tpg_if.pend_cnt), 32'd3);
    chk("t3_ovf_set", 32'(tpg_if.overflow), 32'd1);
    step(1, 1, 1);
    chk("t3_ovf_prio", 32'(tpg_if.overflow), 32'd1);
    step(1, 0, 1);
    chk("t3_ovf_clr", 32'(tpg_if.overflow), 32'd0);
    repeat (5) step(0, 0, 0);

    // enable drops mid-pulse: pulse and gap finish, queue flushed, no more pulses.
    do_reset();
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0);
      if (tpg_if.line_out) cnt++;
    end
    chk("t4_pend_before", 32'(tpg_if.pend_cnt), 32'd2);
    for (int i = 0; i < 40; i++) begin
      step(0, 0, 0);
      if (tpg_if.line_out) cnt++;
      if (i == 0) chk("t4_pend_flushed", 32'(tpg_if.pend_cnt), 32'd0);
    end
    chk("t4_line_cycles", 32'(cnt), 32'(P));
    chk("t4_busy_end", 32'(tpg_if.busy), 32'd0);

    // Asynchronous reset mid-pulse forces the line idle without a clock edge.
    do_reset();
    step(1, 1, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    chk("t5_line_before", 32'(tpg_if.line_out), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_reset", 32'(dut_out()), 32'(6'b000000));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(1, 1, 0);
    step(1, 0, 0);
    chk("t5_pulse_after", 32'(tpg_if.line_out), 32'd1);
    repeat (14) step(1, 0, 0);

    // Request on the gap-end edge with an empty queue: one IDLE cycle, then ASSERT.
    do_reset();
    step(1, 1, 0);
    repeat (14) step(1, 0, 0);
    step(1, 1, 0);
    chk("t6_gapend", 32'({tpg_if.line_out, tpg_if.pend_cnt}), 32'(3'b0_01));
    step(1, 0, 0);
    chk("t6_start", 32'({tpg_if.line_out, tpg_if.pend_cnt}), 32'(3'b1_00));
    repeat (14) step(1, 0, 0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++)
      step(($urandom % 16) != 0, ($urandom % 3) == 0, ($urandom % 8) == 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
